// File: rtl/multdiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: FSM encoding,
// iteration count and the most negative 32-bit value.
package multdiv_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int          ITER_COUNT = 32;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/div_step.sv
// One restoring-divide step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             bit_in,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    // Remainder stays below the divisor, so the shifted value never needs bit WIDTH kept.
    assign shifted = {rem_in, bit_in};
    assign diff    = {1'b0, shifted} - {2'b00, divisor};
    assign q_bit   = ~diff[WIDTH+1];
    assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed 32-bit multiply (radix-2 shift-add) and restoring divide,
// one bit per cycle, with a registered one-cycle ready strobe.
module multdiv_iter
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [WIDTH-1:0]   mcand_reg, mcand_next;
    logic [2*WIDTH-1:0] prod_reg, prod_next;
    logic               neg_reg, neg_next;
    logic               dz_reg, dz_next;
    logic [WIDTH-1:0]   result_reg, result_next;
    logic               exc_reg, exc_next;
    logic               rdy_reg, rdy_next;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               cnt_done;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_shift;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quo_signed;
    logic [WIDTH-1:0]   rem_out;
    logic               q_bit;

    assign mag_a    = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    assign mag_b    = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
    assign cnt_done = (cnt_reg == CNT_W'(ITER_COUNT));

    // prod_reg holds {partial product, multiplier} during MULT and
    // {partial remainder, dividend/quotient} during DIV.
    assign mul_sum   = {1'b0, prod_reg[2*WIDTH-1:WIDTH]}
                     + {1'b0, (prod_reg[0] ? mcand_reg : {WIDTH{1'b0}})};
    assign mul_shift = {mul_sum, prod_reg[WIDTH-1:1]};

    assign prod_signed = neg_reg ? (~prod_reg + 1'b1) : prod_reg;
    assign quo_signed  = neg_reg ? (~prod_reg[WIDTH-1:0] + 1'b1) : prod_reg[WIDTH-1:0];

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in  (prod_reg[2*WIDTH-1:WIDTH]),
        .divisor (mcand_reg),
        .bit_in  (prod_reg[WIDTH-1]),
        .rem_out (rem_out),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            mcand_reg  <= '0;
            prod_reg   <= '0;
            neg_reg    <= 1'b0;
            dz_reg     <= 1'b0;
            result_reg <= '0;
            exc_reg    <= 1'b0;
            rdy_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            mcand_reg  <= mcand_next;
            prod_reg   <= prod_next;
            neg_reg    <= neg_next;
            dz_reg     <= dz_next;
            result_reg <= result_next;
            exc_reg    <= exc_next;
            rdy_reg    <= rdy_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        mcand_next  = mcand_reg;
        prod_next   = prod_reg;
        neg_next    = neg_reg;
        dz_next     = dz_reg;
        result_next = result_reg;
        exc_next    = exc_reg;
        rdy_next    = 1'b0;

        // A start pulse always wins and silently discards any operation in flight.
        if (ctrl_MULT || ctrl_DIV) begin
            state_next = ctrl_MULT ? S_MULT : S_DIV;
            cnt_next   = '0;
            mcand_next = ctrl_MULT ? mag_a : mag_b;
            prod_next  = {{WIDTH{1'b0}}, (ctrl_MULT ? mag_b : mag_a)};
            neg_next   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz_next    = ~ctrl_MULT & ~(|data_operandB);
        end else begin
            case (state_reg)
                S_MULT: begin
                    if (cnt_done) begin
                        state_next  = S_DONE;
                        result_next = prod_signed[WIDTH-1:0];
                        exc_next    = |(prod_signed[2*WIDTH-1:WIDTH]
                                        ^ {WIDTH{prod_signed[WIDTH-1]}});
                        rdy_next    = 1'b1;
                    end else begin
                        prod_next = mul_shift;
                        cnt_next  = cnt_reg + CNT_W'(1);
                    end
                end
                S_DIV: begin
                    if (dz_reg) begin
                        state_next  = S_DONE;
                        result_next = '0;
                        exc_next    = 1'b1;
                        rdy_next    = 1'b1;
                    end else if (cnt_done) begin
                        state_next  = S_DONE;
                        result_next = quo_signed;
                        // Only INT_MIN / -1 yields a positive magnitude with bit 31 set.
                        exc_next    = ~neg_reg & prod_reg[WIDTH-1];
                        rdy_next    = 1'b1;
                    end else begin
                        prod_next = {rem_out, prod_reg[WIDTH-2:0], q_bit};
                        cnt_next  = cnt_reg + CNT_W'(1);
                    end
                end
                S_DONE:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    assign data_result    = result_reg;
    assign data_exception = exc_reg;
    assign data_resultRDY = rdy_reg;

endmodule

// File: doc/multdiv_iter.md
Name: multdiv_iter

Overview:
- Iterative signed 32-bit multiply/divide unit beside the ALU in the execute stage.
- Takes the same 32-bit operands as the ALU, runs a multi-cycle operation and returns a 32-bit result with an exception flag and a one-cycle ready strobe.
- Its zero/overflow checks use the 32-bit OR-reduction style the ALU flag path already uses.
- The pipeline stall logic downstream consumes data_resultRDY.

Parameters:
- WIDTH, 32, operand and result width; only 32 is supported.
- CNT_W, 6, width of the iteration counter; must hold the value WIDTH+1.

Ports:
- clock  input  1  single clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- data_operandA  input  32  multiplicand or dividend, two's complement.
- data_operandB  input  32  multiplier or divisor, two's complement.
- ctrl_MULT  input  1  start pulse for a multiply; operands are sampled on the same edge.
- ctrl_DIV  input  1  start pulse for a divide; operands are sampled on the same edge.
- data_result  output  32  low 32 bits of the product, or the quotient.
- data_exception  output  1  multiply overflow, divide by zero, or divide overflow.
- data_resultRDY  output  1  high for exactly one cycle when result and exception are valid.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, counter=0, internal registers=0.
  - data_result=0, data_exception=0, data_resultRDY=0.
  - Reset asserted mid-operation aborts it; no RDY is produced afterwards.
- States: IDLE, MULT, DIV, DONE.
- Start:
  - At a rising edge with ctrl_MULT=1, operands are latched and state goes to MULT, counter=0.
  - ctrl_DIV=1 does the same into DIV.
  - If both are high, MULT wins.
  - A start in any state, including MULT/DIV/DONE, aborts the current operation and restarts. No RDY is issued for the aborted operation.
- MULT:
  - Radix-2 shift-add on operand magnitudes, one bit per cycle, 32 iterations.
  - Sign applied at the end: negative iff the operand signs differ.
  - data_result = low 32 bits of the 64-bit signed product.
  - data_exception=1 iff the 64-bit product is not the sign extension of bit 31 of that low word.
- DIV:
  - Restoring divide on magnitudes, one quotient bit per cycle, 32 iterations.
  - Quotient truncates toward zero; its sign is the XOR of the operand signs. The remainder is discarded.
  - Divisor==0 is detected on the start edge and the unit goes straight to DONE with result=0, exception=1.
  - 0x80000000 / 0xFFFFFFFF gives result=0x80000000, exception=1.
- Latency, with the start edge as edge 0:
  - Iterations occupy edges 1..32.
  - Edge 33 enters DONE and registers result/exception; RDY is high in the cycle after edge 33.
  - Divide by zero: DONE at edge 1, RDY high in the cycle after edge 1.
- DONE:
  - RDY=1 for one cycle, then IDLE.
  - data_result and data_exception hold their values until the next DONE, or until reset.
- Outputs are registered only; there is no combinational path from inputs to outputs.
- During MULT/DIV, data_result keeps its previous value and RDY=0.
- Operand inputs may change freely after the start edge.

Decomposition:
- Shared package multdiv_pkg:
  - state encoding constants S_IDLE=2'd0, S_MULT=2'd1, S_DIV=2'd2, S_DONE=2'd3.
  - ITER_COUNT=32.
  - constant INT_MIN=32'h80000000.
- One sub-module, div_step:
  - combinational single restoring-divide step.
  - Inputs: partial remainder, divisor magnitude, next dividend bit.
  - Outputs: new remainder and quotient bit.
  - Instantiated once and iterated by the FSM.
- The multiplier add/shift stays inline in multdiv_iter.

Test Plan:
- MULT A=7, B=-3 → RDY exactly 34 cycles after the start edge; result=0xFFFFFFEB (-21), exception=0. RDY high for one cycle only.
- MULT A=0x00010000, B=0x00010000 → result=0x00000000, exception=1. Then MULT A=0x7FFFFFFF, B=1 → result=0x7FFFFFFF, exception=0.
- DIV A=-7, B=2 → result=0xFFFFFFFD (-3), exception=0. Then DIV A=100, B=0 → RDY in the cycle after edge 1, result=0, exception=1.
- DIV A=0x80000000, B=0xFFFFFFFF → result=0x80000000, exception=1. DIV A=0x80000000, B=2 → result=0xC0000000, exception=0.
- Abort and priority cases:
  - Start MULT 5*5, then at edge 10 start DIV 9/3 → exactly one RDY, 34 cycles after the DIV start, with result=3.
  - ctrl_MULT and ctrl_DIV both high with 6,2 → result=12.
- Reset asserted at edge 20 of a multiply → all outputs 0 asynchronously, and no RDY until a new start. After release, MULT 2*3 → result=6.
